// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder, one DATA_LENGTH frame per CS_n.
// Ports: spi_* bus pins, tx_* one-word TX buffer, rx_* word pulse, status.
module spi_slave #(
  parameter int DATA_LENGTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_LENGTH-1:0] TX_DEFAULT = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   tx_underrun
);

  localparam int CW = $clog2(DATA_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_prev;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  logic [DATA_LENGTH-1:0] shift_tx;
  logic [DATA_LENGTH-1:0] shift_rx;
  logic [DATA_LENGTH-1:0] rx_next;
  logic [CW-1:0]          bit_cnt;
  logic [CW-1:0]          cnt_next;
  logic [DATA_LENGTH-1:0] buf_data;
  logic                   buf_full;
  logic                   tx_accept;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  // A CS_n fall only counts once the bus has been seen idle after reset,
  // so a frame already in flight at reset release is ignored.
  assign cs_fall  = armed & ~cs_s & cs_prev;

  assign rx_next   = {shift_rx[DATA_LENGTH-2:0], mosi_s};
  assign cnt_next  = bit_cnt + 1'b1;
  assign tx_ready  = ~buf_full;
  assign tx_accept = tx_valid & ~buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
      // fill marks when reset values have drained out of the chain
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      armed     <= armed | (fill[SYNC_STAGES] & cs_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spi_miso    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      bit_cnt     <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            if (buf_full) begin
              shift_tx <= buf_data;
              spi_miso <= buf_data[DATA_LENGTH-1];
              buf_full <= 1'b0;
            end else begin
              shift_tx    <= TX_DEFAULT;
              spi_miso    <= TX_DEFAULT[DATA_LENGTH-1];
              tx_underrun <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            spi_miso  <= 1'b0;
            frame_err <= 1'b1;
          end else if (sck_rise) begin
            shift_rx <= rx_next;
            bit_cnt  <= cnt_next;
            if (cnt_next == LAST) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              state    <= WAIT_CS;
            end
          end else if (sck_fall && bit_cnt < LAST) begin
            shift_tx <= shift_tx << 1;
            spi_miso <= shift_tx[DATA_LENGTH-2];
          end
        end
        WAIT_CS: begin
          if (cs_rise) begin
            state    <= IDLE;
            busy     <= 1'b0;
            spi_miso <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // accept never overlaps the frame-start drain: it needs an empty buffer
      if (tx_accept) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench acting as SPI master with a queue-based reference model.
// Ports: none; drives spi_slave and scores rx words, MISO words and pulses.
module tb_spi_slave;

  localparam int DL   = 8;
  localparam int SS   = 2;
  localparam int HALF = 6;
  localparam logic [7:0] TXD = 8'h00;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       tx_underrun;

  spi_slave #(
    .DATA_LENGTH(DL),
    .SYNC_STAGES(SS),
    .TX_DEFAULT (TXD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sck    (sck),
    .spi_cs_n   (cs_n),
    .spi_mosi   (mosi),
    .spi_miso   (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .tx_underrun(tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_mdl[$];

  int n_rxv = 0;
  int n_ferr = 0;
  int n_und = 0;
  int e_rxv = 0;
  int e_ferr = 0;
  int e_und = 0;
  logic [7:0] e_rxdata = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_rxv++;
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          chk("rx_data", rx_data, rx_q.pop_front());
        end
      end
      if (frame_err) n_ferr++;
      if (tx_underrun) n_und++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs();
    chk("rst_miso", miso, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {rx_valid, frame_err, tx_underrun}, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    tx_mdl.delete();
    e_rxdata = 8'h00;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rxv"}, n_rxv, e_rxv);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
    chk({tag, "_und"}, n_und, e_und);
  endtask

  task automatic load_tx(input logic [7:0] w);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      tick(1);
      t++;
    end
    chk("load_ready", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_mdl.push_back(w);
  endtask

  // One frame as master. nbits<8 aborts the frame; rst_at>=0 pulses reset
  // before that bit; ld_start loads ld on the frame-start cycle.
  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input bit chk_mi, input int rst_at,
                      input bit ld_start, input logic [7:0] ld);
    logic [7:0] mi;
    logic [7:0] em;
    mi = '0;
    if (tx_mdl.size() > 0) em = tx_mdl.pop_front();
    else begin
      em = TXD;
      e_und++;
    end
    if (nbits == DL && rst_at < 0) begin
      rx_q.push_back(mo);
      e_rxv++;
      e_rxdata = mo;
    end
    cs_n = 1'b0;
    mosi = mo[7];
    if (ld_start) begin
      tick(SS);
      tx_data  = ld;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tx_mdl.push_back(ld);
      tick(HALF - SS - 1);
    end else begin
      tick(HALF);
    end
    chk("busy_start", busy, 1);
    chk("ready_start", tx_ready, !ld_start);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) do_reset();
      mi  = {mi[6:0], miso};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      if (i < DL - 1) mosi = mo[6-i];
      tick(HALF);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(8);
    if (nbits < DL && rst_at < 0) e_ferr++;
    chk("busy_end", busy, 0);
    chk("miso_idle", miso, 0);
    if (chk_mi) chk("miso_word", mi, em);
  endtask

  initial begin
    rst_n    = 1'b0;
    sck      = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    tick(3);
    chk_reset_outs();
    rst_n = 1'b1;
    tick(5);

    // preloaded word, full frame
    load_tx(8'h3C);
    xfer(8'hA5, DL, 1, -1, 0, 0);
    chk_counts("loop");

    // empty buffer: underrun, default word out
    xfer(8'h0F, DL, 1, -1, 0, 0);
    chk_counts("under");

    // abort after 5 bits
    xfer(8'hC3, 5, 0, -1, 0, 0);
    chk("abort_rx_hold", rx_data, e_rxdata);
    chk_counts("abort");
    load_tx(8'h77);
    xfer(8'h81, DL, 1, -1, 0, 0);

    // back-to-back with reloads
    load_tx(8'h11);
    xfer(8'h01, DL, 1, -1, 0, 0);
    load_tx(8'h22);
    xfer(8'hFF, DL, 1, -1, 0, 0);
    load_tx(8'h33);
    xfer(8'h80, DL, 1, -1, 0, 0);
    chk_counts("b2b");

    // reset mid-frame, then a normal frame
    load_tx(8'h99);
    xfer(8'hE7, DL, 0, 3, 0, 0);
    chk("post_rst_rx", rx_data, 0);
    chk_counts("rstf");
    xfer(8'h5A, DL, 1, -1, 0, 0);
    chk_counts("after_rst");

    // SCK noise while deselected
    for (int i = 0; i < DL; i++) begin
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      tick(HALF);
    end
    chk_counts("noise");
    xfer(8'h3E, DL, 1, -1, 1, 8'hB4);
    xfer(8'h42, DL, 1, -1, 0, 0);
    chk_counts("ld_start");

    // randomized frames
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      xfer(8'($urandom), DL, 1, -1, 0, 0);
    end
    tick(4);
    chk_counts("final");
    chk("rx_q_empty", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
